uart_sample_arbiter: RTL and testbench
======================================

# uart_sample_arbiter

Shares the single UART transmit path between up to four 16-bit sample sources. Holds one sample per channel, selects pending channels round-robin, and sends each sample as a 3-byte packet (header, low byte, high byte). Sits between the sample producers and the UART transmitter, and handshakes byte-by-byte on the transmitter's busy flag.

## Interface
- NUM_CH, 4, number of requesting channels, legal range 2..4
- HDR_NIBBLE, 4'hA, upper nibble of every header byte
- BUSY_TIMEOUT, 15, cycles to wait for in_tx_busy to rise after a start pulse, legal range 1..255
- in_clk  input  1  single clock; all logic on the rising edge
- in_rst_n  input  1  reset, synchronous and active-low
- in_sample_valid  input  NUM_CH  one-cycle pulse per channel: sample present
- in_samples  input  16*NUM_CH  channel i sample is bits [16*i+15:16*i]
- in_tx_busy  input  1  UART transmitter busy
- in_clear_overrun  input  1  clears all overrun flags
- out_uart_frame  output  8  byte presented to the transmitter
- out_tx_start  output  1  one-cycle pulse: transmitter loads out_uart_frame
- out_overrun  output  NUM_CH  sticky per-channel sample-dropped flag
- out_busy  output  1  high whenever the FSM is not in IDLE

## Operation
- Per-channel holding register and pending bit.
  - valid[i] with pending[i]=0: load sample, set pending.
  - valid[i] with pending[i]=1: drop the new sample, keep the old one, set overrun[i].
  - Exception: if the FSM captures channel i in the same cycle, load the new sample, pending stays 1, no overrun.
- out_overrun: set wins over in_clear_overrun when both occur in the same cycle for the same channel.
- Round-robin pointer last_ch:
  - Reset value NUM_CH-1, so channel 0 wins first.
  - The search starts at last_ch+1 (mod NUM_CH). The first pending channel found is granted.
- FSM states:
  - IDLE: if any channel is pending, capture the granted sample into the work register, clear its pending bit, set last_ch, set byte_idx=0, go to START. Otherwise stay.
  - START: stay while in_tx_busy=1. When in_tx_busy=0, register out_uart_frame and pulse out_tx_start for 1 cycle, then go to WAIT_BUSY.
  - Frame contents by byte_idx: 0 = {HDR_NIBBLE, 2'b00, ch[1:0]}, 1 = sample[7:0], 2 = sample[15:8].
  - WAIT_BUSY: go to WAIT_DONE when in_tx_busy=1. Also go to WAIT_DONE once the timeout counter reaches BUSY_TIMEOUT; the byte is then treated as sent.
  - WAIT_DONE: when in_tx_busy=0, go to START with byte_idx+1 if byte_idx<2. Otherwise go to IDLE.
- A packet is never interrupted. New valids during a packet only update the holding registers.

## Timing
- Reset (in_rst_n=0 at an edge) applies in any state:
  - FSM goes to IDLE.
  - out_uart_frame=8'h00, out_tx_start=0, out_busy=0.
  - pending, overrun, byte_idx and the timeout counter clear.
  - last_ch=NUM_CH-1.
  - A packet in flight is abandoned with no further start pulses.
- Latency with an idle arbiter and in_tx_busy=0, taking valid at edge k:
  - pending is set after edge k.
  - Grant happens at edge k+1.
  - out_tx_start is high between edge k+2 and edge k+3, with the header on out_uart_frame.
- Gap between bytes: the next start comes at the earliest 1 cycle after in_tx_busy falls (WAIT_DONE→START, then START→pulse).
- out_uart_frame holds its value until the next start. out_tx_start is never high for 2 consecutive cycles.
- Back-to-back packets: IDLE is entered for exactly 1 cycle between packets. The grant happens in that cycle.
- Timeout counter: cleared on entering WAIT_BUSY and incremented each cycle in WAIT_BUSY.

## Test plan
- Single channel: valid[0]=1 with sample 16'h1234, transmitter model with 10-cycle busy → bytes A0, 34, 12 in order, first start at k+2, out_busy low after the last busy falls.
- Round-robin: all 4 channels valid in the same cycle with samples 16'h0001..16'h0004 → packet order ch0, ch1, ch2, ch3; headers A0, A1, A2, A3.
- Overrun: second valid on ch1 (16'hBEEF) while a ch0 packet is in flight and ch1 already holds 16'hCAFE → ch1 sends CAFE, out_overrun[1]=1; in_clear_overrun clears it.
- Busy timeout: transmitter never asserts busy → 3 start pulses, each BUSY_TIMEOUT+1 or more cycles apart, then FSM returns to IDLE.
- Reset mid-packet: in_rst_n=0 for 1 cycle after the low byte is started → no high-byte start, all outputs at reset values; the next ch0 sample sends a complete packet.
- Capture collision: valid[2] in the same cycle that ch2 is granted → the old sample is sent, the new sample stays pending, out_overrun[2]=0.

Source files
------------

// File: rtl/uart_sample_arbiter.sv
// uart_sample_arbiter
// Shares one UART transmit path between NUM_CH 16-bit sample sources. Each
// channel has a one-deep holding register; pending channels are served
// round-robin and each sample goes out as a 3-byte packet
// (header {HDR_NIBBLE, 2'b00, ch}, sample low byte, sample high byte),
// handshaking byte-by-byte on the transmitter's busy flag.
//
// Ports
//   in_clk            clock, rising edge
//   in_rst_n          synchronous active-low reset
//   in_sample_valid   per-channel one-cycle sample strobe
//   in_samples        channel i sample at bits [16*i+15:16*i]
//   in_tx_busy        UART transmitter busy
//   in_clear_overrun  clears all overrun flags
//   out_uart_frame    byte presented to the transmitter (held until next start)
//   out_tx_start      one-cycle load strobe for the transmitter
//   out_overrun       sticky per-channel sample-dropped flags
//   out_busy          high whenever the packet FSM is not idle
module uart_sample_arbiter #(
    parameter int         NUM_CH       = 4,
    parameter logic [3:0] HDR_NIBBLE   = 4'hA,
    parameter int         BUSY_TIMEOUT = 15
) (
    input  logic                   in_clk,
    input  logic                   in_rst_n,
    input  logic [NUM_CH-1:0]      in_sample_valid,
    input  logic [16*NUM_CH-1:0]   in_samples,
    input  logic                   in_tx_busy,
    input  logic                   in_clear_overrun,
    output logic [7:0]             out_uart_frame,
    output logic                   out_tx_start,
    output logic [NUM_CH-1:0]      out_overrun,
    output logic                   out_busy
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    localparam logic [1:0] LAST_RST = 2'(NUM_CH - 1);
    localparam logic [7:0] TMO_MAX  = 8'(BUSY_TIMEOUT);

    state_t             state;
    state_t             state_nxt;
    logic [15:0]        hold [NUM_CH];
    logic [NUM_CH-1:0]  pending;
    logic [1:0]         last_ch;
    logic [15:0]        work_sample;
    logic [1:0]         work_ch;
    logic [1:0]         byte_idx;
    logic [7:0]         tmo_cnt;
    logic               grant_vld;
    logic [1:0]         grant_ch;
    logic [NUM_CH-1:0]  cap_vec;
    logic               capture;
    logic               start_fire;
    logic [7:0]         frame_nxt;

    // Channel reached by stepping 'off' places past 'base', wrapping at NUM_CH.
    function automatic logic [1:0] rr_idx(input logic [1:0] base, input int off);
        int t;
        t = int'(base) + off;
        if (t >= NUM_CH) t = t - NUM_CH;
        return 2'(t);
    endfunction

    function automatic logic [7:0] frame_byte(input logic [1:0] idx,
                                              input logic [1:0] ch,
                                              input logic [15:0] s);
        case (idx)
            2'd0:    return {HDR_NIBBLE, 2'b00, ch};
            2'd1:    return s[7:0];
            default: return s[15:8];
        endcase
    endfunction

    // Round-robin search: first pending channel after last_ch wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = 2'd0;
        for (int j = 1; j <= NUM_CH; j++) begin
            if (!grant_vld && pending[rr_idx(last_ch, j)]) begin
                grant_vld = 1'b1;
                grant_ch  = rr_idx(last_ch, j);
            end
        end
    end

    // FSM: state register
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) state <= S_IDLE;
        else           state <= state_nxt;
    end

    // FSM: next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (grant_vld) state_nxt = S_START;
            S_START:     if (!in_tx_busy) state_nxt = S_WAIT_BUSY;
            // A transmitter that never raises busy is assumed to have taken the byte.
            S_WAIT_BUSY: if (in_tx_busy || tmo_cnt == TMO_MAX) state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: if (!in_tx_busy) state_nxt = (byte_idx < 2'd2) ? S_START : S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs / strobes
    always_comb begin
        capture    = (state == S_IDLE) && grant_vld;
        start_fire = (state == S_START) && !in_tx_busy;
        out_busy   = (state != S_IDLE);
        frame_nxt  = frame_byte(byte_idx, work_ch, work_sample);
        cap_vec    = '0;
        if (capture) cap_vec[grant_ch] = 1'b1;
    end

    // Control state: pointer, byte index, timeout, pending/overrun, UART outputs
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            last_ch        <= LAST_RST;
            byte_idx       <= 2'd0;
            tmo_cnt        <= 8'd0;
            pending        <= '0;
            out_overrun    <= '0;
            out_tx_start   <= 1'b0;
            out_uart_frame <= 8'h00;
        end else begin
            out_tx_start <= start_fire;
            if (start_fire) out_uart_frame <= frame_nxt;

            if (capture) begin
                last_ch  <= grant_ch;
                byte_idx <= 2'd0;
            end else if (state == S_WAIT_DONE && !in_tx_busy && byte_idx < 2'd2) begin
                byte_idx <= byte_idx + 2'd1;
            end

            if (start_fire)                tmo_cnt <= 8'd0;
            else if (state == S_WAIT_BUSY) tmo_cnt <= tmo_cnt + 8'd1;

            for (int i = 0; i < NUM_CH; i++) begin
                // A strobe landing on the capture cycle refills the slot just emptied.
                if (cap_vec[i])              pending[i] <= in_sample_valid[i];
                else if (in_sample_valid[i]) pending[i] <= 1'b1;

                if (in_sample_valid[i] && pending[i] && !cap_vec[i]) out_overrun[i] <= 1'b1;
                else if (in_clear_overrun)                           out_overrun[i] <= 1'b0;
            end
        end
    end

    // Sample datapath: holding registers and the packet work register
    always_ff @(posedge in_clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (in_sample_valid[i] && (!pending[i] || cap_vec[i]))
                hold[i] <= in_samples[16*i +: 16];
        end
        if (capture) begin
            work_sample <= hold[grant_ch];
            work_ch     <= grant_ch;
        end
    end

endmodule

// File: tb/tb_uart_sample_arbiter.sv
module tb_uart_sample_arbiter;

    localparam int NCH      = 4;
    localparam int TMO      = 15;
    localparam int BUSY_LEN = 10;

    logic                in_clk;
    logic                in_rst_n;
    logic [NCH-1:0]      in_sample_valid;
    logic [16*NCH-1:0]   in_samples;
    logic                in_tx_busy;
    logic                in_clear_overrun;
    logic [7:0]          out_uart_frame;
    logic                out_tx_start;
    logic [NCH-1:0]      out_overrun;
    logic                out_busy;

    uart_sample_arbiter #(.NUM_CH(NCH), .HDR_NIBBLE(4'hA), .BUSY_TIMEOUT(TMO)) dut (
        .in_clk           (in_clk),
        .in_rst_n         (in_rst_n),
        .in_sample_valid  (in_sample_valid),
        .in_samples       (in_samples),
        .in_tx_busy       (in_tx_busy),
        .in_clear_overrun (in_clear_overrun),
        .out_uart_frame   (out_uart_frame),
        .out_tx_start     (out_tx_start),
        .out_overrun      (out_overrun),
        .out_busy         (out_busy)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    bit         tx_never = 1'b0;
    logic [7:0] byte_q[$];
    int         cyc_q[$];

    // Reference model state
    int          mdl_last;
    bit          mp[NCH];
    logic [15:0] mv[NCH];
    logic [7:0]  exp_q[$];
    logic [3:0]  exp_ovr;

    initial begin
        in_clk = 1'b0;
        forever #5 in_clk = ~in_clk;
    end

    initial forever begin
        @(posedge in_clk);
        cyc++;
    end

    // Transmit monitor
    initial forever begin
        @(negedge in_clk);
        if (out_tx_start) begin
            byte_q.push_back(out_uart_frame);
            cyc_q.push_back(cyc);
        end
    end

    // Transmitter model: busy for BUSY_LEN cycles after each start
    initial begin
        in_tx_busy = 1'b0;
        forever begin
            @(negedge in_clk);
            if (out_tx_start && !tx_never) begin
                in_tx_busy = 1'b1;
                repeat (BUSY_LEN) @(negedge in_clk);
                in_tx_busy = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_sample(input int ch, input logic [15:0] v);
        in_samples[16*ch +: 16] = v;
    endtask

    task automatic pulse_valid(input logic [NCH-1:0] m);
        in_sample_valid = m;
        @(negedge in_clk);
        in_sample_valid = '0;
    endtask

    task automatic do_reset();
        in_rst_n = 1'b0;
        in_sample_valid = '0;
        @(negedge in_clk);
        in_rst_n = 1'b1;
        mdl_last = NCH - 1;
    endtask

    task automatic clear_log();
        byte_q.delete();
        cyc_q.delete();
    endtask

    task automatic wait_bytes(input string tag, input int n, input int budget);
        int b = 0;
        while (byte_q.size() < n && b < budget) begin
            @(negedge in_clk);
            b++;
        end
        check(tag, 32'(byte_q.size() >= n), 32'd1);
    endtask

    // Idle means FSM and transmitter both quiet for three samples in a row.
    task automatic wait_idle(input string tag, input int budget);
        int quiet = 0;
        int b = 0;
        while (quiet < 3 && b < budget) begin
            @(negedge in_clk);
            b++;
            if (!out_busy && !in_tx_busy) quiet++;
            else quiet = 0;
        end
        check(tag, 32'(quiet >= 3), 32'd1);
    endtask

    function automatic void mdl_emit(input int ch);
        exp_q.push_back({4'hA, 2'b00, 2'(ch)});
        exp_q.push_back(mv[ch][7:0]);
        exp_q.push_back(mv[ch][15:8]);
        mp[ch] = 1'b0;
        mdl_last = ch;
    endfunction

    // Next pending channel after mdl_last in circular order, -1 if none.
    function automatic int mdl_pick();
        for (int j = 1; j <= NCH; j++) begin
            if (mp[(mdl_last + j) % NCH]) return (mdl_last + j) % NCH;
        end
        return -1;
    endfunction

    task automatic compare_bytes(input string tag);
        check({tag, "_count"}, 32'(byte_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < byte_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), 32'(byte_q[i]), 32'(exp_q[i]));
    endtask

    initial begin
        int k;
        int min_gap;
        logic [3:0] m;
        logic [15:0] v;

        in_rst_n = 1'b0;
        in_sample_valid = '0;
        in_samples = '0;
        in_clear_overrun = 1'b0;
        mdl_last = NCH - 1;
        repeat (2) @(negedge in_clk);

        // Reset state
        check("rst_frame", 32'(out_uart_frame), 32'h00);
        check("rst_start", 32'(out_tx_start), 32'd0);
        check("rst_overrun", 32'(out_overrun), 32'd0);
        check("rst_busy", 32'(out_busy), 32'd0);
        in_rst_n = 1'b1;
        @(negedge in_clk);

        // Single channel packet and first-start latency
        clear_log();
        set_sample(0, 16'h1234);
        k = cyc + 1;
        pulse_valid(4'b0001);
        wait_bytes("single_wait", 3, 200);
        wait_idle("single_idle", 200);
        exp_q = '{8'hA0, 8'h34, 8'h12};
        compare_bytes("single");
        check("single_latency", 32'(cyc_q[0]), 32'(k + 2));
        check("single_busy_low", 32'(out_busy), 32'd0);

        // Round-robin from reset: ch0..ch3
        do_reset();
        clear_log();
        for (int i = 0; i < NCH; i++) set_sample(i, 16'(i + 1));
        pulse_valid(4'b1111);
        wait_bytes("rr_wait", 12, 800);
        wait_idle("rr_idle", 200);
        exp_q = '{8'hA0, 8'h01, 8'h00, 8'hA1, 8'h02, 8'h00,
                  8'hA2, 8'h03, 8'h00, 8'hA3, 8'h04, 8'h00};
        compare_bytes("rr");

        // Overrun on a channel still waiting its turn
        do_reset();
        clear_log();
        set_sample(0, 16'h1111);
        set_sample(1, 16'hCAFE);
        pulse_valid(4'b0011);
        wait_bytes("ovr_wait1", 1, 100);
        set_sample(1, 16'hBEEF);
        pulse_valid(4'b0010);
        check("ovr_set", 32'(out_overrun), 32'h2);
        wait_bytes("ovr_wait2", 6, 400);
        wait_idle("ovr_idle", 200);
        exp_q = '{8'hA0, 8'h11, 8'h11, 8'hA1, 8'hFE, 8'hCA};
        compare_bytes("ovr");
        check("ovr_sticky", 32'(out_overrun), 32'h2);
        in_clear_overrun = 1'b1;
        @(negedge in_clk);
        in_clear_overrun = 1'b0;
        check("ovr_cleared", 32'(out_overrun), 32'h0);

        // Busy timeout: transmitter never responds
        do_reset();
        clear_log();
        tx_never = 1'b1;
        set_sample(3, 16'h5678);
        pulse_valid(4'b1000);
        wait_bytes("tmo_wait", 3, 300);
        wait_idle("tmo_idle", 200);
        exp_q = '{8'hA3, 8'h78, 8'h56};
        compare_bytes("tmo");
        if (cyc_q.size() >= 3) begin
            check("tmo_gap1", 32'(cyc_q[1] - cyc_q[0] >= TMO + 1), 32'd1);
            check("tmo_gap2", 32'(cyc_q[2] - cyc_q[1] >= TMO + 1), 32'd1);
        end
        check("tmo_busy_low", 32'(out_busy), 32'd0);
        tx_never = 1'b0;

        // Reset mid-packet after the low byte starts
        do_reset();
        clear_log();
        set_sample(0, 16'hABCD);
        pulse_valid(4'b0001);
        wait_bytes("midrst_wait", 2, 200);
        in_rst_n = 1'b0;
        @(negedge in_clk);
        check("midrst_frame", 32'(out_uart_frame), 32'h00);
        check("midrst_start", 32'(out_tx_start), 32'd0);
        check("midrst_busy", 32'(out_busy), 32'd0);
        check("midrst_overrun", 32'(out_overrun), 32'd0);
        in_rst_n = 1'b1;
        mdl_last = NCH - 1;
        wait_idle("midrst_idle", 200);
        repeat (20) @(negedge in_clk);
        check("midrst_no_high", 32'(byte_q.size()), 32'd2);
        clear_log();
        set_sample(0, 16'h0F0E);
        pulse_valid(4'b0001);
        wait_bytes("midrst_wait2", 3, 200);
        wait_idle("midrst_idle2", 200);
        exp_q = '{8'hA0, 8'h0E, 8'h0F};
        compare_bytes("midrst_after");

        // Valid arriving on the capture cycle of the same channel
        do_reset();
        clear_log();
        set_sample(2, 16'h1111);
        in_sample_valid = 4'b0100;
        @(negedge in_clk);
        set_sample(2, 16'h2222);
        @(negedge in_clk);
        in_sample_valid = '0;
        check("coll_no_ovr", 32'(out_overrun), 32'h0);
        wait_bytes("coll_wait", 6, 400);
        wait_idle("coll_idle", 200);
        exp_q = '{8'hA2, 8'h11, 8'h11, 8'hA2, 8'h22, 8'h22};
        compare_bytes("coll");
        check("coll_ovr_end", 32'(out_overrun), 32'h0);

        // Randomized batches against the round-robin reference model
        do_reset();
        for (int it = 0; it < 20; it++) begin
            clear_log();
            exp_q.delete();
            exp_ovr = '0;
            in_clear_overrun = 1'b1;
            @(negedge in_clk);
            in_clear_overrun = 1'b0;
            m = 4'($urandom_range(1, 15));
            for (int i = 0; i < NCH; i++) begin
                v = 16'($urandom);
                set_sample(i, v);
                mp[i] = m[i];
                mv[i] = v;
            end
            pulse_valid(m);
            mdl_emit(mdl_pick());
            wait_bytes($sformatf("rnd%0d_first", it), 1, 100);
            if ($urandom_range(0, 1) == 1) begin
                k = int'($urandom_range(0, NCH - 1));
                v = 16'($urandom);
                set_sample(k, v);
                pulse_valid(4'(1 << k));
                if (mp[k]) exp_ovr[k] = 1'b1;
                else begin
                    mp[k] = 1'b1;
                    mv[k] = v;
                end
            end
            while (mdl_pick() >= 0) mdl_emit(mdl_pick());
            wait_bytes($sformatf("rnd%0d_all", it), exp_q.size(), 1200);
            wait_idle($sformatf("rnd%0d_idle", it), 200);
            compare_bytes($sformatf("rnd%0d", it));
            check($sformatf("rnd%0d_ovr", it), 32'(out_overrun), 32'(exp_ovr));
            min_gap = 1000;
            for (int i = 1; i < cyc_q.size(); i++)
                if (cyc_q[i] - cyc_q[i-1] < min_gap) min_gap = cyc_q[i] - cyc_q[i-1];
            check($sformatf("rnd%0d_start_gap", it), 32'(min_gap >= 2), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
